instr_encoder: RTL and testbench

- Loader-side counterpart of the instruction decoder.
- Accepts MIPS instruction fields over a valid/ready stream, packs them into 32-bit R/I/J words and writes them to consecutive instruction-memory addresses.
- Sits between the test/boot host and the instruction memory write port; it programs the imem before the core is released from reset.

---
 rtl/instr_enc_pkg.sv | 8 +
 rtl/instr_field_pack.sv | 23 ++
 rtl/instr_encoder.sv | 101 ++++++++++
 tb/tb_instr_encoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: format codes, loader states and opcode/funct constants shared with the decoder.
package instr_enc_pkg;
  localparam logic [1:0] FMT_R = 2'b00, FMT_I = 2'b01, FMT_J = 2'b10, FMT_RSVD = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08, FUNCT_JALR = 6'h09;
endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: packs MIPS R/I/J fields into a 32-bit word; the reserved format yields a nop.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);
  always_comb begin
    word    = fmt == FMT_R ? {opcode, rs, rt, rd, shamt, funct} :
              fmt == FMT_I ? {opcode, rs, rt, imm} :
              fmt == FMT_J ? {opcode, target} : 32'h0;
    illegal = fmt == FMT_RSVD;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams instruction fields into consecutive imem words before core release.
// Optional INSTR_ENC_CHECKSUM_EN adds a running XOR of all written words.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              illegal,
  output logic [ADDR_W:0]   word_count
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              bad, acc, full, fin;
  instr_field_pack u_pack (
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target), .word(word), .illegal(bad)
  );
  assign acc  = in_valid & in_ready;
  assign full = ptr == LAST;
  assign busy = state != ST_IDLE;
  // fin marks the write cycle of the closing word; DONE follows once it retires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      illegal    <= 1'b0;
      word_count <= '0;
      ptr        <= BASE;
      fin        <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      imem_we <= acc;
      if (acc) begin
        imem_addr  <= ptr;
        imem_wdata <= word;
        ptr        <= full ? ptr : ptr + 1'b1;
        word_count <= word_count + 1'b1;
        illegal    <= illegal | bad;
`ifdef INSTR_ENC_CHECKSUM_EN
        checksum   <= checksum ^ word;
`endif
        if (in_last || full) begin
          in_ready <= 1'b0;
          fin      <= 1'b1;
          overflow <= full & ~in_last;
        end
      end
      if (state == ST_LOAD && fin) begin
        state <= ST_DONE;
        done  <= 1'b1;
        fin   <= 1'b0;
      end else if (state != ST_LOAD && start) begin
        state      <= ST_LOAD;
        in_ready   <= 1'b1;
        ptr        <= BASE;
        word_count <= '0;
        done       <= 1'b0;
        overflow   <= 1'b0;
        illegal    <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
        checksum   <= '0;
`endif
      end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors against hand-computed imem writes (ADDR_W=2 so capacity is reachable).
module tb_instr_encoder;
  import instr_enc_pkg::*;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
  logic [1:0]  fmt = 0;
  logic [5:0]  opcode = 0, funct = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0, shamt = 0;
  logic [15:0] imm = 0;
  logic [25:0] target = 0;
  logic        in_ready, imem_we, busy, done, overflow, illegal;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  word_count;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int n = 0, bad = 0, cyc = 0;
  int wa[$], wc[$], ac[$], wr[$];
  logic [31:0] wd[$];

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .target(target), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .overflow(overflow), .illegal(illegal), .word_count(word_count)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(int'(imem_addr));
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
      wr.push_back(int'(in_ready));
    end
    if (in_valid && in_ready) ac.push_back(cyc + 1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete(); ac.delete(); wr.delete();
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [4:0] s, input logic [5:0] fn,
                      input logic [15:0] im, input logic [25:0] tg, input logic last);
    bit ok = 0;
    fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = s; funct = fn; imm = im; target = tg;
    in_last = last; in_valid = 1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk);
      ok = in_ready;
    end
    #1;
    chk("accept", 32'(ok), 1);
  endtask

  task automatic settle();
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_flags", {busy, done, overflow, illegal}, 0);
    chk("rst_count", 32'(word_count), 0);
    @(posedge clk); #1 rst_n = 1;

    clr(); pulse_start();
    chk("load_busy", 32'(busy), 1);
    chk("load_ready", 32'(in_ready), 1);
    send(FMT_R, OP_RTYPE, 1, 2, 3, 0, 6'h20, 0, 0, 1);
    settle();
    chk("r_nwr", wa.size(), 1);
    chk("r_addr", wa[0], 0);
    chk("r_data", wd[0], 32'h00221820);
    chk("r_lat", wc[0], ac[0]);
    chk("r_done", {done, in_ready, overflow}, 3'b100);
    chk("r_count", 32'(word_count), 1);

    clr(); pulse_start();
    chk("restart_done", 32'(done), 0);
    send(FMT_I, OP_LW, 29, 8, 0, 0, 0, 16'h0004, 0, 0);
    send(FMT_J, OP_J, 0, 0, 0, 0, 0, 0, 26'h0100000, 0);
    send(FMT_R, OP_RTYPE, 31, 0, 0, 0, FUNCT_JR, 0, 0, 1);
    settle();
    chk("s3_nwr", wa.size(), 3);
    chk("s3_a0", wa[0], 0); chk("s3_a1", wa[1], 1); chk("s3_a2", wa[2], 2);
    chk("s3_d0", wd[0], 32'h8FA80004);
    chk("s3_d1", wd[1], 32'h08100000);
    chk("s3_d2", wd[2], 32'h03E00008);
    chk("s3_b2b1", wc[1], wc[0] + 1);
    chk("s3_b2b2", wc[2], wc[0] + 2);
    chk("s3_end", {done, overflow, illegal}, 3'b100);
    chk("s3_count", 32'(word_count), 3);
`ifdef INSTR_ENC_CHECKSUM_EN
    chk("s3_csum", checksum, 32'h8458000C);
`endif

    clr(); pulse_start();
    fmt = FMT_I; opcode = OP_SW; rs = 4; rt = 5; imm = 16'h0010; in_last = 0; in_valid = 1;
    repeat (8) @(posedge clk);
    #1 in_valid = 0;
    settle();
    chk("ov_nacc", ac.size(), 4);
    chk("ov_nwr", wa.size(), 4);
    for (int i = 0; i < 4; i++) chk("ov_addr", wa[i], i);
    chk("ov_data", wd[3], 32'hAC850010);
    chk("ov_rdy_last_wr", wr[3], 0);
    chk("ov_flags", {done, overflow, in_ready}, 3'b110);
    chk("ov_count", 32'(word_count), 4);

    clr(); pulse_start();
    chk("ov_cleared", 32'(overflow), 0);
    send(FMT_RSVD, 6'h3F, 7, 7, 7, 7, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 0);
    send(FMT_I, OP_BEQ, 1, 2, 0, 0, 0, 16'hFFFE, 0, 1);
    settle();
    chk("il_nwr", wa.size(), 2);
    chk("il_d0", wd[0], 32'h00000000);
    chk("il_d1", wd[1], 32'h1022FFFE);
    chk("il_flags", {illegal, done, overflow}, 3'b110);

    clr(); pulse_start();
    chk("il_cleared", 32'(illegal), 0);
    send(FMT_I, OP_LW, 1, 2, 0, 0, 0, 16'h0001, 0, 0);
    send(FMT_I, OP_LW, 1, 3, 0, 0, 0, 16'h0002, 0, 0);
    fmt = FMT_I; opcode = OP_LW; rs = 1; rt = 4; imm = 16'h0003; in_last = 0;
    #6 rst_n = 0;
    #1;
    chk("ar_we", 32'(imem_we), 0);
    chk("ar_ready", 32'(in_ready), 0);
    chk("ar_flags", {busy, done, overflow, illegal}, 0);
    chk("ar_addr", 32'(imem_addr), 0);
    chk("ar_wdata", imem_wdata, 0);
    chk("ar_count", 32'(word_count), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("ar_nwr", wa.size(), 2);
    in_valid = 0; rst_n = 1;
    clr(); pulse_start();
    send(FMT_J, OP_JAL, 0, 0, 0, 0, 0, 0, 26'h0000040, 1);
    settle();
    chk("ar_re_nwr", wa.size(), 1);
    chk("ar_re_addr", wa[0], 0);
    chk("ar_re_data", wd[0], 32'h0C000040);
    chk("ar_re_count", 32'(word_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
